// File: rtl/crc16_checker.sv
// Serial CRC-16 (x^16 + x^15 + x^2 + 1, MSB-first, clear value 0) for the USB receive path.
// Optional macro CRC16_MATCH_EN adds a combinational crc_ok flag (remainder == 0).
module crc16_checker (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        d_decoded,
    input  logic        enable,
    input  logic        init,
    output logic [15:0] check_16
`ifdef CRC16_MATCH_EN
    ,
    output logic        crc_ok
`endif
);

    localparam logic [15:0] POLY = 16'h8005;

    logic        fb;
    logic [15:0] shifted;

    // fb is only consumed when enable=1, so an X on d_decoded during gaps never reaches the register.
    always_comb begin
        fb      = check_16[15] ^ d_decoded;
        shifted = {check_16[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end

    // n_rst is active-high despite its name; init outranks enable.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            check_16 <= 16'h0000;
        end else if (init) begin
            check_16 <= 16'h0000;
        end else if (enable) begin
            check_16 <= shifted;
        end
    end

`ifdef CRC16_MATCH_EN
    assign crc_ok = (check_16 == 16'h0000);
`endif

endmodule

// File: tb/tb_crc16_checker.sv
// Self-checking bench for crc16_checker: per-cycle scoreboard against a bit-serial reference
// model plus fixed known-answer values; covers crc_ok when CRC16_MATCH_EN is defined.
module tb_crc16_checker;

  logic        clk;
  logic        n_rst;
  logic        d_decoded;
  logic        enable;
  logic        init;
  logic [15:0] check_16;
`ifdef CRC16_MATCH_EN
  logic        crc_ok;
`endif

  int n_checks;
  int n_pass;

  logic [15:0] mdl;
  logic [15:0] exp_q[$];

  crc16_checker dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_decoded (d_decoded),
    .enable    (enable),
    .init      (init),
    .check_16  (check_16)
`ifdef CRC16_MATCH_EN
    ,
    .crc_ok    (crc_ok)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, want);
    end
  endtask

  // Reference: long-division step for polynomial 0x8005, MSB-first.
  function automatic logic [15:0] ref_step(input logic [15:0] r, input logic b);
    logic [16:0] t;
    t = {r, 1'b0};
    if (r[15] ^ b) t = t ^ 17'h18005;
    return t[15:0];
  endfunction

  // driver: apply one cycle of inputs, push the expected remainder, compare after the edge
  task automatic step(input string tag, input logic rst, input logic ini, input logic en, input logic d);
    logic [15:0] e;
    @(negedge clk);
    n_rst     = rst;
    init      = ini;
    enable    = en;
    d_decoded = d;
    if (rst || ini) mdl = 16'h0000;
    else if (en)    mdl = ref_step(mdl, d);
    exp_q.push_back(mdl);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_q_empty"}, 16'hFFFF, 16'h0000);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, check_16, e);
`ifdef CRC16_MATCH_EN
      check_eq({tag, "_ok"}, {15'd0, crc_ok}, {15'd0, (e == 16'h0000)});
`endif
    end
  endtask

  task automatic shift_word(input string tag, input logic [15:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      step(tag, 1'b0, 1'b0, 1'b1, w[i]);
    end
  endtask

  initial begin
    logic [15:0] held;
    n_checks  = 0;
    n_pass    = 0;
    mdl       = 16'h0000;
    n_rst     = 1'b1;
    init      = 1'b0;
    enable    = 1'b0;
    d_decoded = 1'b1;

    // reset: two cycles with d=1, enable=0
    step("reset0", 1'b1, 1'b0, 1'b0, 1'b1);
    step("reset1", 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("reset_kat", check_16, 16'h0000);

    // generate CRC of 0xCF
    step("gen_clr", 1'b0, 1'b1, 1'b0, 1'b0);
    shift_word("gen", 16'h00CF, 8);
    check_eq("gen_kat", check_16, 16'h02A2);

    // check without init: reset, then data + CRC
    step("chk_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    shift_word("chk_d", 16'h00CF, 8);
    shift_word("chk_c", 16'h02A2, 16);
    check_eq("chk_kat", check_16, 16'h0000);

    // init priority from a nonzero state
    shift_word("pre_init", 16'h00A5, 8);
    check_eq("pre_init_nz", {15'd0, (check_16 != 16'h0000)}, 16'h0001);
    step("init_pri", 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("init_kat", check_16, 16'h0000);
    shift_word("ini_d", 16'h00CF, 8);
    shift_word("ini_c", 16'h02A2, 16);
    check_eq("ini_kat", check_16, 16'h0000);

    // held init: stays clear every cycle
    for (int i = 0; i < 3; i++) step("init_held", 1'b0, 1'b1, 1'b1, 1'(i));

    // error detect: wrong CRC, with an enable gap mid-stream
    shift_word("err_d", 16'h00CF, 8);
    shift_word("err_c_hi", 16'h0002, 8);
    held = check_16;
    for (int i = 0; i < 5; i++) begin
      step("gap", 1'b0, 1'b0, 1'b0, 1'(i & 1));
      check_eq("gap_hold", check_16, held);
    end
    step("gap_x", 1'b0, 1'b0, 1'b0, 1'bx);
    check_eq("gap_x_hold", check_16, held);
    shift_word("err_c_lo", 16'h00A3, 8);
    check_eq("err_nz", {15'd0, (check_16 != 16'h0000)}, 16'h0001);

    // mid-field reset
    step("mid_clr", 1'b0, 1'b1, 1'b0, 1'b0);
    shift_word("mid_part", 16'h000C, 4);
    check_eq("mid_part_nz", {15'd0, (check_16 != 16'h0000)}, 16'h0001);
    step("mid_rst", 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("mid_rst_kat", check_16, 16'h0000);
    shift_word("mid_d", 16'h00CF, 8);
    shift_word("mid_c", 16'h02A2, 16);
    check_eq("mid_kat", check_16, 16'h0000);

    // random stream with random enable gaps against the model
    for (int i = 0; i < 200; i++) begin
      step("rand", 1'b0, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    if (exp_q.size() != 0) check_eq("q_leftover", 16'(exp_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
